// File: rtl/tdc_frame_source.sv
// tdc_frame_source: measures clk cycles between synchronised start/stop rising edges
// and streams each result as a SYNC/flags/result byte frame over valid/ready.
module tdc_frame_source #(
   parameter int         WIDTH       = 16,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   output logic [7:0] axi_data,
   output logic       axi_valid,
   input  logic       axi_ready,
   output logic       busy
);
   localparam int         NB   = WIDTH / 8;
   localparam logic [2:0] LAST = 3'(NB + 1);

   typedef enum logic [1:0] {IDLE, COUNT, SEND} state_t;

   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_start_sync, r_stop_sync;
   logic                   r_start_d, r_stop_d;
   logic [WIDTH-1:0]       r_count, r_result;
   logic                   r_ovf;
   logic [2:0]             r_idx;
   logic                   w_start_edge, w_stop_edge, w_xfer, w_last;
   logic [7:0]             w_byte;

   assign w_start_edge = r_start_sync[SYNC_STAGES-1] & ~r_start_d;
   assign w_stop_edge  = r_stop_sync[SYNC_STAGES-1] & ~r_stop_d;
   assign w_xfer       = (r_state == SEND) && axi_ready;
   assign w_last       = r_idx == LAST;

   // Frame byte order: sync, flags, then result bytes MSB first
   always_comb begin
      w_byte = (r_idx == 3'd0) ? SYNC_BYTE : {7'b0, r_ovf};
      for (int k = 0; k < NB; k++)
         if (r_idx == 3'(k + 2)) w_byte = r_result[WIDTH-1-8*k -: 8];
   end

   always_comb begin
      w_next    = r_state;
      axi_valid = r_state == SEND;
      axi_data  = (r_state == SEND) ? w_byte : 8'h00;
      busy      = r_state != IDLE;
      if (r_state == IDLE && w_start_edge) w_next = w_stop_edge ? SEND : COUNT;
      if (r_state == COUNT && w_stop_edge) w_next = SEND;
      if (w_xfer && w_last) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_start_sync <= '0;
         r_stop_sync  <= '0;
         r_start_d    <= 1'b0;
         r_stop_d     <= 1'b0;
         r_count      <= '0;
         r_result     <= '0;
         r_ovf        <= 1'b0;
         r_idx        <= 3'd0;
      end else begin
         r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start};
         r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], stop};
         r_start_d    <= r_start_sync[SYNC_STAGES-1];
         r_stop_d     <= r_stop_sync[SYNC_STAGES-1];
         if (r_state == IDLE && w_start_edge) begin
            r_count  <= WIDTH'(1);
            r_result <= '0;
            r_ovf    <= 1'b0;
         end
         // Count saturates; an increment refused at full scale flags overflow
         if (r_state == COUNT) begin
            if (w_stop_edge)   r_result <= r_count;
            else if (&r_count) r_ovf    <= 1'b1;
            else               r_count  <= r_count + WIDTH'(1);
         end
         if (w_xfer) r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
      end
   end
endmodule

// File: doc/tdc_frame_source.md
Name: tdc_frame_source

Overview:
- Time-to-digital measurement front end that sits directly upstream of the UART transmitter and drives its byte-stream input (axi_data/axi_valid/axi_ready).
- Synchronises the raw start/stop pins and counts clk cycles between a start rising edge and a stop rising edge.
- Emits each result as a fixed-length byte frame over a valid/ready handshake.

Parameters:
- WIDTH, 16, counter/result width in bits; must be a multiple of 8, legal range 8..32.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; minimum 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next clk edge).
- start  input  1  raw asynchronous start pin.
- stop  input  1  raw asynchronous stop pin.
- axi_data  output  8  frame byte to the UART.
- axi_valid  output  1  axi_data holds a byte to be transferred.
- axi_ready  input  1  UART accepts the byte this cycle.
- busy  output  1  high in COUNT or SEND; low in IDLE.

Behaviour:
- Reset: state=IDLE; axi_valid=0, axi_data=8'h00, busy=0; counter, result, ovf and byte index cleared; synchroniser and edge-detect flops cleared to 0.
- Input path:
  - start and stop each pass through a SYNC_STAGES-deep synchroniser, then a 1-flop rising-edge detector.
  - The resulting edge pulse is one cycle wide.
  - Both paths have identical latency, so the pin-to-pin delta is preserved.
- States: IDLE, COUNT, SEND.
- IDLE:
  - start_edge with no stop_edge: count<=1, ovf<=0, go to COUNT.
  - start_edge and stop_edge in the same cycle: result<=0, ovf<=0, go to SEND.
  - stop_edge alone is ignored.
- COUNT:
  - stop_edge: result<=count, go to SEND.
  - Otherwise count<=count+1, saturating at 2^WIDTH-1.
  - An increment attempted at saturation sets ovf=1 (sticky until the next start).
  - start_edge in COUNT is ignored; the measurement does not restart.
  - Result therefore equals (stop_edge cycle - start_edge cycle), saturating.
- SEND:
  - Frame length is 2+WIDTH/8 bytes, in order:
    - SYNC_BYTE;
    - flags byte {7'b0, ovf};
    - result bytes, MSB byte first.
  - axi_valid rises on the cycle SEND is entered.
  - A byte transfers on an edge where axi_valid&&axi_ready. The next byte appears the following cycle and axi_valid stays high (back-to-back capable).
  - While axi_valid=1 and axi_ready=0, axi_data and axi_valid hold stable.
  - When the last byte is accepted: go to IDLE; axi_valid=0 and axi_data=8'h00 the next cycle.
  - start and stop edges during SEND are discarded; they are not queued.
- IDLE/COUNT: axi_valid=0, regardless of axi_ready.
- Reset mid-operation: rst=0 in any state returns every output to its reset value on the next edge. A partial frame is abandoned and is not resumed.
- axi_ready is sampled only when axi_valid=1; ready-before-valid carries no meaning.

Test Plan:
1. Reset with rst=0 for 3 cycles while start/stop toggle -> axi_valid=0, busy=0, axi_data=00 throughout. No frame follows release unless a new start edge occurs.
2. start pulse, stop pulse 10 cycles later, axi_ready=1 constant -> frame A5 00 00 0A on 4 consecutive cycles; busy low the cycle after the last byte.
3. start and stop rising in the same cycle -> frame A5 00 00 00.
4. WIDTH=8, stop 300 cycles after start -> frame A5 01 FF (saturated, ovf set).
5. Measurement of 0x1234 with axi_ready toggling 1-0-0-1-… -> bytes A5 00 12 34 delivered in order. axi_data is unchanged during every ready-low stall, and no byte is duplicated or dropped.
6. Second start edge during COUNT, and start/stop edges during SEND -> the first measurement is unaffected and no extra frame is produced. rst=0 asserted after byte 2 of a frame -> axi_valid=0 next cycle, and the following measurement sends a complete fresh frame.
